// File: rtl/psr_ddc_pkg.sv
// Shared DDC output-path definitions: width-select encodings and the
// mode-to-samples-per-word mapping used by the sample packer.
package psr_ddc_pkg;

  typedef enum logic [1:0] {
    WSEL_8   = 2'd0,
    WSEL_16  = 2'd1,
    WSEL_4   = 2'd2,
    WSEL_RSV = 2'd3
  } wsel_e;

  // Reserved encoding falls back to 1:1.
  function automatic logic [2:0] samples_per_word(input logic [1:0] sel);
    case (sel)
      WSEL_8:  return 3'd2;
      WSEL_4:  return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/width_sel_pack.sv
// Keeps the top 1/N of each framed sample and packs N slices MSB-first per
// output word; partial words are zero-padded and flushed at frame end.
module width_sel_pack #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_sync_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        width_sel,
  output logic              valid_out,
  output logic              en_sync_out,
  output logic [CNT_W-1:0]  cnt_sync_out,
  output logic [DATA_W-1:0] data_out
);
  import psr_ddc_pkg::*;

  localparam int Q = DATA_W / 4;

  // Word is handled as four quarters; each slot owns 4/N of them and is
  // filled from the top 4/N quarters of the incoming sample.
  function automatic logic [DATA_W-1:0] insert_slice(
    input logic [DATA_W-1:0] base,
    input logic [DATA_W-1:0] smp,
    input logic [1:0]        slot,
    input logic [2:0]        n
  );
    logic [DATA_W-1:0] w;
    int owner, sub;
    w = base;
    for (int j = 0; j < 4; j++) begin
      case (n)
        3'd1:    begin owner = 0;     sub = j;     end
        3'd2:    begin owner = j / 2; sub = j % 2; end
        default: begin owner = j;     sub = 0;     end
      endcase
      if (owner == int'(slot))
        w[DATA_W-1-j*Q -: Q] = smp[DATA_W-1-sub*Q -: Q];
    end
    return w;
  endfunction

  logic [1:0]        mode_q, slot_q, cur_mode, cur_slot;
  logic [2:0]        n;
  logic [DATA_W-1:0] pack_q, packed_nxt, emit_word;
  logic [CNT_W-1:0]  wcnt_q, cur_idx;
  logic              en_d, flush_q;
  logic              frame_start, word_done, flush, emit;

  always_comb begin
    frame_start = en_sync_in & ~en_d;
    cur_mode    = frame_start ? width_sel : mode_q;
    n           = samples_per_word(cur_mode);
    cur_slot    = frame_start ? 2'd0 : slot_q;
    cur_idx     = frame_start ? '0 : wcnt_q;
    // Starting each word from zero makes flushed words zero-padded for free.
    packed_nxt  = insert_slice((cur_slot == 2'd0) ? '0 : pack_q, data_in, cur_slot, n);
    word_done   = en_sync_in & (3'(cur_slot) == n - 3'd1);
    flush       = ~en_sync_in & (slot_q != 2'd0);
    emit        = word_done | flush;
    emit_word   = flush ? pack_q : packed_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= WSEL_16;
      slot_q       <= '0;
      pack_q       <= '0;
      wcnt_q       <= '0;
      en_d         <= 1'b0;
      flush_q      <= 1'b0;
      valid_out    <= 1'b0;
      en_sync_out  <= 1'b0;
      cnt_sync_out <= '0;
      data_out     <= '0;
    end else begin
      en_d      <= en_sync_in;
      flush_q   <= flush;
      valid_out <= emit;
      // A flush is always the last word of its frame, so the gate drops after it.
      en_sync_out <= emit | (en_sync_out & en_sync_in & ~flush_q);
      if (frame_start) mode_q <= width_sel;
      if (!en_sync_in || word_done) slot_q <= '0;
      else                          slot_q <= cur_slot + 2'd1;
      if (en_sync_in) pack_q <= packed_nxt;
      if (emit) begin
        data_out     <= emit_word;
        cnt_sync_out <= cur_idx;
        wcnt_q       <= cur_idx + CNT_W'(1);
      end else if (frame_start) begin
        wcnt_q <= '0;
      end
    end
  end

endmodule
